// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: owner and FSM encodings plus default sizing.
package imem_arbiter_pkg;

    localparam int unsigned DEFAULT_DEPTH      = 128;
    localparam int unsigned DEFAULT_STARVE_MAX = 4;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned BADDR_W            = 32;

    // Which requester owns the outstanding response
    typedef enum logic {
        OWN_F = 1'b0,
        OWN_L = 1'b1
    } owner_e;

    // Response FSM: the state itself records {valid, owner} of the pending response
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_F = 2'd1,
        RESP_L = 2'd2
    } state_e;

    // One-entry outstanding response record
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
        logic   rd;
    } resp_t;

    // Next FSM state from the grant taken in the current cycle
    function automatic state_e resp_state(logic granted, owner_e owner);
        if (!granted) begin
            return IDLE;
        end
        return (owner == OWN_L) ? RESP_L : RESP_F;
    endfunction

endpackage

// File: rtl/imem_arbiter_addr_check.sv
// Byte-address decode: word index into the memory and legality (aligned and in range).
module imem_addr_check
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned IDX_W = 7
) (
    input  logic [BADDR_W-1:0] addr,
    output logic [IDX_W-1:0]   word_idx,
    output logic               legal
);

    // Word index is the byte address with the two offset bits dropped; anything above the array is illegal
    always_comb begin
        word_idx = addr[IDX_W+1:2];
        legal    = (addr[1:0] == 2'b00) && ((addr >> (IDX_W + 2)) == BADDR_W'(0));
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-requester arbiter (fetch read port, loader read/write port) onto a single-cycle-latency instruction memory.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     f_req,
    input  logic [31:0]              f_addr,
    output logic                     f_gnt,
    output logic                     f_rvalid,
    output logic [31:0]              f_rdata,
    output logic                     f_err,

    input  logic                     l_req,
    input  logic                     l_we,
    input  logic [31:0]              l_addr,
    input  logic [31:0]              l_wdata,
    output logic                     l_gnt,
    output logic                     l_rvalid,
    output logic [31:0]              l_rdata,
    output logic                     l_err,

    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    state_e          state_q;
    state_e          state_d;
    logic [SW-1:0]   starve_q;
    logic [SW-1:0]   starve_d;
    resp_t           resp_q;
    logic [31:0]     sel_addr;
    logic [AW-1:0]   word_idx;
    logic            legal;
    logic            granted;
    owner_e          grant_owner;

    imem_addr_check #(
        .IDX_W (AW)
    ) u_addr_check (
        .addr     (sel_addr),
        .word_idx (word_idx),
        .legal    (legal)
    );

    // Arbitration, starvation counter and next FSM state; loader wins unless fetch has waited STARVE_MAX grants
    always_comb begin
        f_gnt       = 1'b0;
        l_gnt       = 1'b0;
        sel_addr    = f_addr;
        grant_owner = OWN_F;
        starve_d    = starve_q;

        if (rst) begin
            if (l_req && !(f_req && (starve_q == SW'(STARVE_MAX)))) begin
                l_gnt       = 1'b1;
                sel_addr    = l_addr;
                grant_owner = OWN_L;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end

        granted = f_gnt | l_gnt;
        state_d = resp_state(granted, grant_owner);

        if (!f_req || f_gnt) begin
            starve_d = '0;
        end else if (l_gnt && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Memory port driven in the grant cycle; illegal accesses never reach the array
    always_comb begin
        mem_en    = granted & legal;
        mem_we    = l_gnt & legal & l_we;
        mem_addr  = word_idx;
        mem_wdata = l_gnt ? l_wdata : '0;
    end

    // FSM, starvation counter and the registered response handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            resp_q   <= '0;
            f_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            f_err    <= 1'b0;
            l_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            resp_q.valid <= granted;
            resp_q.owner <= grant_owner;
            resp_q.err   <= granted & ~legal;
            resp_q.rd    <= granted & legal & ~(l_gnt & l_we);
            f_rvalid     <= f_gnt;
            l_rvalid     <= l_gnt;
            f_err        <= f_gnt & ~legal;
            l_err        <= l_gnt & ~legal;
        end
    end

    // Read data: the memory's own output register, steered to the owner of the pending legal read
    always_comb begin
        f_rdata = '0;
        l_rdata = '0;
        if (resp_q.valid && resp_q.rd && !resp_q.err) begin
            if ((state_q == RESP_F) && (resp_q.owner == OWN_F)) begin
                f_rdata = mem_rdata;
            end
            if ((state_q == RESP_L) && (resp_q.owner == OWN_L)) begin
                l_rdata = mem_rdata;
            end
        end
    end

endmodule
